fir_error_monitor: RTL
======================

FIR_ERROR_MONITOR -- requirements
Module: fir_error_monitor

Interface
REQ-001 SHALL provide parameter DATA_W, default 17: sample width, two's complement.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 16: reference alignment buffer entries, power of 2.
REQ-003 SHALL provide parameter TOL, default 4: absolute error tolerance in LSBs.
REQ-004 SHALL provide parameter CNT_W, default 16: width of the sample and error counters.
REQ-005 SHALL provide port clk_100MHz, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL provide port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL provide port start, input, 1: pulse that begins a run.
REQ-008 SHALL provide port num_samples, input, CNT_W: number of comparisons in the run, sampled at start.
REQ-009 SHALL provide port ref_valid, input, 1: reference sample valid.
REQ-010 SHALL provide port ref_data, input, DATA_W: reference sample.
REQ-011 SHALL provide port ref_ready, output, 1: monitor can accept a reference sample.
REQ-012 SHALL provide port dut_valid, input, 1: filter output valid; no backpressure.
REQ-013 SHALL provide port dut_data, input, DATA_W: filter output sample.
REQ-014 SHALL provide port abs_err, output, DATA_W+1: |dut - ref| of the last comparison.
REQ-015 SHALL provide port abs_err_valid, output, 1: one-cycle strobe for abs_err.
REQ-016 SHALL provide port err_count, output, CNT_W: comparisons with abs_err > TOL, plus underflows.
REQ-017 SHALL provide port max_abs_err, output, DATA_W+1: largest abs_err seen in the run.
REQ-018 SHALL provide port underflow, output, 1: sticky; a DUT sample arrived with the buffer empty.
REQ-019 SHALL provide port done, output, 1: run complete.
REQ-020 SHALL provide port pass, output, 1: valid while done is 1.

Function
REQ-021 SHALL implement the FSM IDLE, RUN and DONE.
REQ-022 start in IDLE or DONE SHALL do all of the following in one cycle: clear counters, max_abs_err, underflow, done and pass; flush the FIFO; latch num_samples; enter RUN.
REQ-023 start with num_samples = 0 SHALL enter DONE directly with pass = 1; start in RUN SHALL be ignored.
REQ-024 ref_ready SHALL equal (state == RUN) && FIFO not full.
REQ-025 A push SHALL occur when ref_valid && ref_ready.
REQ-026 In RUN, dut_valid SHALL always be accepted.
REQ-027 A DUT sample accepted with the FIFO non-empty SHALL pop the oldest ref sample and compare the pair.
REQ-028 Compare arithmetic: sign-extend both operands to DATA_W+1 bits, subtract, take the magnitude; the result SHALL be exact (no saturation).
REQ-029 abs_err and abs_err_valid SHALL be registered, with latency 1 cycle from the dut_valid edge.
REQ-030 Each comparison: err_count SHALL increment if abs_err > TOL (abs_err == TOL is a pass).
REQ-031 Each comparison: max_abs_err SHALL update if abs_err is strictly greater.
REQ-032 err_count SHALL saturate at all-ones.
REQ-033 A DUT sample accepted with the FIFO empty SHALL:
  - set underflow;
  - increment err_count;
  - count as a comparison;
  - not assert abs_err_valid.
REQ-034 A same-cycle push and DUT sample with the FIFO empty SHALL be an underflow; the pushed sample SHALL stay buffered.
REQ-035 A same-cycle push and pop with the FIFO non-empty SHALL both occur; occupancy SHALL be unchanged.
REQ-036 The FIFO pointers SHALL wrap modulo FIFO_DEPTH, with a separate occupancy count for full/empty.
REQ-037 When the comparison count reaches num_samples, the FSM SHALL enter DONE on the cycle after the last compare, once its err_count and max updates are visible.
REQ-038 In DONE: done = 1, pass = (err_count == 0) && !underflow; ref_ready = 0; dut_valid SHALL be ignored.
REQ-039 In IDLE and DONE, inputs SHALL NOT alter any statistic.

Reset
REQ-040 reset SHALL asynchronously force all of the following: state IDLE; FIFO empty; counters 0; abs_err 0; abs_err_valid 0; err_count 0; max_abs_err 0; underflow 0; done 0; pass 0; ref_ready 0.
REQ-041 reset asserted mid-run SHALL abort the run with no partial results retained; the next run SHALL require start.

Verification
REQ-042 Scenario: num_samples = 4; push refs 100, -50, 0, 7; DUT 100, -47, 5, 7 -> abs_err 0, 3, 5, 0; err_count 1; max_abs_err 5; done = 1; pass = 0.
REQ-043 Scenario: DUT -65536 vs ref 65535 (DATA_W = 17) -> abs_err 131071, no wrap; err_count increments.
REQ-044 Scenario: push 16 refs with no DUT -> ref_ready = 0 after the 16th; a 17th ref_valid is not accepted; one DUT sample followed by a push in the same cycle keeps the FIFO full.
REQ-045 Scenario: dut_valid with the FIFO empty (a push in the same cycle) -> underflow = 1; err_count = 1; the pushed ref pairs with the next DUT sample.
REQ-046 Scenario: reset pulsed after 2 of 4 compares -> all outputs 0 and state IDLE; a restart with num_samples = 1 and an exact match -> done = 1, pass = 1.
REQ-047 Scenario: start with num_samples = 0 -> done = 1 and pass = 1 the next cycle; start asserted during RUN has no effect.

Source files
------------

// File: rtl/fir_error_monitor.sv
// fir_error_monitor
//   Compares a filter's output stream against a reference stream and keeps
//   run statistics. Reference samples are queued in a small alignment FIFO.
//   Each accepted filter sample pops the oldest reference and the pair is
//   compared. A filter sample that finds the FIFO empty is an underflow: it is
//   counted as a failed comparison.
//
// Ports
//   clk_100MHz    in   single clock, rising edge
//   reset         in   asynchronous, active-high
//   start         in   pulse; begins a run (ignored while a run is active)
//   num_samples   in   comparisons in the run, latched at start
//   ref_valid     in   reference sample valid
//   ref_data      in   reference sample, two's complement
//   ref_ready     out  reference sample can be accepted this cycle
//   dut_valid     in   filter sample valid (no backpressure)
//   dut_data      in   filter sample, two's complement
//   abs_err       out  |dut - ref| of the last paired comparison
//   abs_err_valid out  one-cycle strobe for abs_err
//   err_count     out  comparisons over TOL plus underflows, saturating
//   max_abs_err   out  largest abs_err seen in the run
//   underflow     out  sticky; a filter sample arrived with the FIFO empty
//   done          out  run complete
//   pass          out  no errors and no underflow; meaningful while done = 1
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset; waiting for start, inputs ignored
// RUN   | accepting references and filter samples, comparing
// DONE  | run complete, statistics frozen, waiting for a new start

module fir_error_monitor #(
  parameter int DATA_W     = 17,
  parameter int FIFO_DEPTH = 16,
  parameter int TOL        = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic              ref_valid,
  input  logic [DATA_W-1:0] ref_data,
  output logic              ref_ready,
  input  logic              dut_valid,
  input  logic [DATA_W-1:0] dut_data,
  output logic [DATA_W:0]   abs_err,
  output logic              abs_err_valid,
  output logic [CNT_W-1:0]  err_count,
  output logic [DATA_W:0]   max_abs_err,
  output logic              underflow,
  output logic              done,
  output logic              pass
);

  localparam int AW    = DATA_W + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
  localparam logic [AW-1:0]    TOL_V    = AW'(TOL);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic [CNT_W-1:0]  cmp_left;

  logic              start_ok;
  logic              fifo_full, fifo_empty;
  logic              push, dut_acc, pop, miss, last_cmp;
  logic [AW-1:0]     dut_sx, ref_sx, diff, abs_cmp;
  logic              err_inc;

  // ---------------------------------------------------------------------------
  // Handshake and event decode
  // ---------------------------------------------------------------------------
  assign start_ok   = start && (state != RUN);
  assign fifo_full  = (occ == OCC_FULL);
  assign fifo_empty = (occ == '0);
  assign ref_ready  = (state == RUN) && !fifo_full;
  assign push       = ref_valid && ref_ready;
  assign dut_acc    = (state == RUN) && dut_valid;
  // Emptiness is judged on the registered occupancy, so a reference pushed in
  // the same cycle as an underflowing filter sample stays queued for the next.
  assign pop        = dut_acc && !fifo_empty;
  assign miss       = dut_acc && fifo_empty;
  // cmp_left is a down-counter; the run ends on the comparison that takes it
  // from one to zero.
  assign last_cmp   = dut_acc && (cmp_left == CNT_ONE);

  // ---------------------------------------------------------------------------
  // Compare: both operands sign-extended by one bit, so the difference and its
  // magnitude are exact for every input pair (worst case 2^DATA_W - 1).
  // ---------------------------------------------------------------------------
  assign dut_sx  = {dut_data[DATA_W-1], dut_data};
  assign ref_sx  = {mem[rd_ptr][DATA_W-1], mem[rd_ptr]};
  assign diff    = dut_sx - ref_sx;
  assign abs_cmp = diff[AW-1] ? (~diff + 1'b1) : diff;
  assign err_inc = miss || (pop && (abs_cmp > TOL_V));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    pass      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = (num_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_cmp) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state == DONE) begin
      done = 1'b1;
      pass = (err_count == '0) && !underflow;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference FIFO storage; contents need no reset since occupancy gates reads.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100MHz) begin
    if (push) begin
      mem[wr_ptr] <= ref_data;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers, comparison counter and statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occ           <= '0;
      cmp_left      <= '0;
      abs_err       <= '0;
      abs_err_valid <= 1'b0;
      err_count     <= '0;
      max_abs_err   <= '0;
      underflow     <= 1'b0;
    end else if (start_ok) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occ           <= '0;
      cmp_left      <= num_samples;
      abs_err       <= '0;
      abs_err_valid <= 1'b0;
      err_count     <= '0;
      max_abs_err   <= '0;
      underflow     <= 1'b0;
    end else begin
      abs_err_valid <= pop;

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        abs_err <= abs_cmp;
        if (abs_cmp > max_abs_err) begin
          max_abs_err <= abs_cmp;
        end
      end

      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase

      if (miss) begin
        underflow <= 1'b1;
      end
      if (err_inc && (err_count != '1)) begin
        err_count <= err_count + 1'b1;
      end
      if (dut_acc) begin
        cmp_left <= cmp_left - 1'b1;
      end
    end
  end

endmodule
